// File: rtl/mem_arbiter_icache.sv
// -----------------------------------------------------------------------------
// mem_arbiter_icache
//
// Shares one byte-serial memory-controller task interface between NUM_DP data
// clients and one instruction-fetch client. Fetches are served from a
// direct-mapped, one-word-per-line instruction cache when it hits. Otherwise
// they compete with the data ports for the controller. Data ports always beat
// an instruction miss. Among the data ports the winner is either the lowest
// index (ARB_RR = 0) or the first requester at or after a rotating pointer
// (ARB_RR = 1).
//
// Build option:
//   MEM_ARB_ICACHE_EN  defined   -> instruction cache storage present
//                      undefined -> no storage, every fetch is a miss
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   rdy_in             global ready; low freezes state and blocks grants
//   clear_in           pipeline flush; blocks issue, drops in-flight responses
//   inst_*             fetch request/grant and instruction response
//   dp_*               per-port data requests (packed, port k at slice k),
//                      one-hot grant/valid, shared load data
//   mc_*               task issue to, and completion from, the controller
// -----------------------------------------------------------------------------
module mem_arbiter_icache #(
    parameter int NUM_DP       = 2,
    parameter int ICACHE_IDX_W = 6,
    parameter int ARB_RR       = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,

    input  logic                  inst_req,
    input  logic [31:0]           inst_addr,
    output logic                  inst_grant,
    output logic                  inst_valid,
    output logic [31:0]           inst_data,

    input  logic [NUM_DP-1:0]     dp_req,
    input  logic [NUM_DP-1:0]     dp_write,
    input  logic [32*NUM_DP-1:0]  dp_addr,
    input  logic [32*NUM_DP-1:0]  dp_wdata,
    input  logic [3*NUM_DP-1:0]   dp_type,
    output logic [NUM_DP-1:0]     dp_grant,
    output logic [NUM_DP-1:0]     dp_valid,
    output logic [31:0]           dp_rdata,

    output logic                  mc_new_task,
    output logic                  mc_is_write,
    output logic [31:0]           mc_addr,
    output logic [31:0]           mc_wdata,
    output logic [2:0]            mc_type,
    input  logic                  mc_busy,
    input  logic                  mc_done,
    input  logic [31:0]           mc_rdata
);

    localparam int DP_W = (NUM_DP > 1) ? $clog2(NUM_DP) : 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DP
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [DP_W-1:0]   owner_idx_q, owner_idx_d;
    logic              drop_q, drop_d;
    logic [DP_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              active;
    logic              hit_raw;
    logic [31:0]       hit_line;
    logic              dp_found;
    logic [DP_W-1:0]   dp_win;
    logic [DP_W-1:0]   scan_idx;

    // Reset and rdy_in both silence every combinational output.
    assign active = rdy_in && !rst_in;

    // -------------------------------------------------------------------------
    // Data-port winner. Round-robin scans from rr_ptr_q, fixed scans from 0.
    // -------------------------------------------------------------------------
    always_comb begin
        dp_found = 1'b0;
        dp_win   = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_DP; i++) begin
            if (ARB_RR != 0) scan_idx = DP_W'((int'(rr_ptr_q) + i) % NUM_DP);
            else             scan_idx = DP_W'(i);
            if (!dp_found && dp_req[scan_idx]) begin
                dp_found = 1'b1;
                dp_win   = scan_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Instruction cache storage
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    logic [LINES-1:0]        line_valid_q;
    logic [TAG_W-1:0]        line_tag_q  [LINES];
    logic [31:0]             line_data_q [LINES];
    logic [29:0]             fill_word_q;
    logic                    fill_we;
    logic                    miss_issue;
    logic [ICACHE_IDX_W-1:0] fetch_idx;
    logic [ICACHE_IDX_W-1:0] fill_idx;

    assign fetch_idx  = inst_addr[2 +: ICACHE_IDX_W];
    assign fill_idx   = fill_word_q[ICACHE_IDX_W-1:0];
    // The lookup reads the registered arrays, so a fill landing this cycle is
    // invisible to a hit test in the same cycle.
    assign hit_raw    = line_valid_q[fetch_idx] &&
                        (line_tag_q[fetch_idx] == inst_addr[31 -: TAG_W]);
    assign hit_line   = line_data_q[fetch_idx];
    assign miss_issue = (state_q == S_IDLE) && (owner_d == OWN_INST);
    // Fills happen even when the response is being dropped by a clear.
    assign fill_we    = active && (state_q == S_BUSY) &&
                        (owner_q == OWN_INST) && mc_done;

    always_ff @(posedge clk_in) begin
        if (rst_in)       line_valid_q <= '0;
        else if (fill_we) line_valid_q[fill_idx] <= 1'b1;
    end

    // NOTE: only the valid bits need reset; tag/data contents are never
    // observed while their valid bit is clear, so the arrays stay reset-free.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            line_tag_q[fill_idx]  <= fill_word_q[29 -: TAG_W];
            line_data_q[fill_idx] <= mc_rdata;
        end
    end

    // Miss address is held for the fill because inst_addr may move on.
    always_ff @(posedge clk_in) begin
        if (miss_issue) fill_word_q <= inst_addr[31:2];
    end
`else
    assign hit_raw  = 1'b0;
    assign hit_line = '0;
`endif

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every output and next-state value gets a default before the case
    // so no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_idx_d = owner_idx_q;
        drop_d      = drop_q;
        rr_ptr_d    = rr_ptr_q;

        inst_grant  = 1'b0;
        inst_valid  = 1'b0;
        inst_data   = '0;
        dp_grant    = '0;
        dp_valid    = '0;
        dp_rdata    = '0;
        mc_new_task = 1'b0;
        mc_is_write = 1'b0;
        mc_addr     = '0;
        mc_wdata    = '0;
        mc_type     = '0;

        // Hits are served in any state, clear or not.
        if (active && inst_req && hit_raw) begin
            inst_grant = 1'b1;
            inst_valid = 1'b1;
            inst_data  = hit_line;
        end

        case (state_q)
            S_IDLE: begin
                if (active && !mc_busy && !clear_in) begin
                    if (dp_found) begin
                        dp_grant[dp_win] = 1'b1;
                        mc_new_task      = 1'b1;
                        mc_is_write      = dp_write[dp_win];
                        mc_addr          = dp_addr[32*int'(dp_win) +: 32];
                        mc_wdata         = dp_wdata[32*int'(dp_win) +: 32];
                        mc_type          = dp_type[3*int'(dp_win) +: 3];
                        owner_d          = OWN_DP;
                        owner_idx_d      = dp_win;
                        rr_ptr_d         = (dp_win == DP_W'(NUM_DP - 1)) ? '0 : dp_win + 1'b1;
                        state_d          = S_BUSY;
                    end else if (inst_req && !hit_raw) begin
                        inst_grant  = 1'b1;
                        mc_new_task = 1'b1;
                        mc_addr     = inst_addr;
                        mc_type     = 3'b010;
                        owner_d     = OWN_INST;
                        state_d     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (active) begin
                    if (clear_in) drop_d = 1'b1;
                    if (mc_done) begin
                        // A clear on the completion cycle itself also drops.
                        if (!drop_q && !clear_in) begin
                            if (owner_q == OWN_DP) begin
                                dp_valid[owner_idx_q] = 1'b1;
                                dp_rdata              = mc_rdata;
                            end else if (owner_q == OWN_INST) begin
                                // Fill response overrides a same-cycle hit.
                                inst_valid = 1'b1;
                                inst_data  = mc_rdata;
                            end
                        end
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                        drop_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            owner_idx_q <= '0;
            drop_q      <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_idx_q <= owner_idx_d;
            drop_q      <= drop_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: doc/mem_arbiter_icache.md
Name: mem_arbiter_icache

Overview:
- Parametrised successor of the single-inst/single-data cache front end.
- Arbitrates NUM_DP data ports plus one instruction port onto one shared memory-controller task interface.
- Instruction port is backed by a direct-mapped, one-word-per-line instruction cache with configurable depth.
- Sits between fetcher/LSB clients and the byte-serial memory controller. Supports fixed or round-robin priority among data ports, and a pipeline-clear input.

Parameters:
- NUM_DP, 2, number of data client ports (1..4).
- ICACHE_IDX_W, 6, log2 of instruction-cache line count (64 lines, 1 word each).
- ARB_RR, 0: 0 = fixed priority (lower data-port index wins); 1 = round-robin among data ports.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; when low, all state holds and no grants are issued
- clear_in  in  1  pipeline clear (ROB flush)
- inst_req  in  1  instruction fetch request
- inst_addr  in  32  fetch address, word aligned
- inst_grant  out  1  request accepted this cycle (hit or miss issued)
- inst_valid  out  1  instruction word valid
- inst_data  out  32  instruction word
- dp_req  in  NUM_DP  per-port data request
- dp_write  in  NUM_DP  per-port 1 = store
- dp_addr  in  32*NUM_DP  per-port address, port k at [32k+31:32k]
- dp_wdata  in  32*NUM_DP  per-port store data
- dp_type  in  3*NUM_DP  per-port {signed, size[1:0]}; size 00 = byte, 01 = half, 10 = word
- dp_grant  out  NUM_DP  one-hot port accepted this cycle
- dp_valid  out  NUM_DP  one-hot completion (load data or store done)
- dp_rdata  out  32  load data, shared by all ports
- mc_new_task  out  1  issue task to memory controller
- mc_is_write  out  1  task is a store
- mc_addr  out  32  task address
- mc_wdata  out  32  task store data
- mc_type  out  3  task type
- mc_busy  in  1  controller busy with a task
- mc_done  in  1  one-cycle task completion pulse
- mc_rdata  in  32  controller load result

Behaviour:
- Reset: FSM = IDLE, owner = none, rr_ptr = 0, all cache valid bits cleared. Every output is 0.
- Inst hit (combinational): inst_req, valid[idx] set, and tag matches addr[31:2+ICACHE_IDX_W] → inst_grant = inst_valid = 1 and inst_data = line in the same cycle, in any FSM state, including during a clear.
- States:
  - IDLE: task may issue.
  - BUSY: owner recorded; waiting for mc_done.
- IDLE issue condition: !mc_busy && !clear_in && rdy_in. Data ports take priority over an instruction miss. The winner gets a one-cycle grant and mc_new_task = 1 with its fields on mc_*; owner is latched and the FSM moves to BUSY. The inst miss issues with type 010 and is_write = 0.
- Fixed priority: lowest asserted index wins.
- Round-robin: search starts at rr_ptr. After each data grant, rr_ptr = winner+1, wrapping modulo NUM_DP.
- BUSY, on mc_done:
  - Owner dp k, no clear in progress: dp_valid[k] = 1 and dp_rdata = mc_rdata.
  - Owner inst: the line is written (valid, tag, data). If no clear is in progress, inst_valid = 1 and inst_data = mc_rdata.
  - In all cases the FSM returns to IDLE. A new issue is allowed the following cycle, never in the same cycle.
- clear_in: no grants and no issue that cycle.
  - If asserted in BUSY, a sticky drop flag is set; the outstanding task still completes.
  - Completion under the drop flag: load/inst responses are suppressed, but the inst fill is still written to the cache; a store completes silently.
  - The drop flag clears on return to IDLE.
- Simultaneous hit and miss-fill on the same index: the fill wins, and the hit compares against the pre-write contents.
- Reset mid-task: immediate return to the reset state; the late mc_done is ignored because owner = none.
- rdy_in low: registers hold and combinational grants are forced to 0.

Optional Feature:
- Macro MEM_ARB_ICACHE_EN.
- Defined: instruction cache behaves as above.
- Undefined: no cache storage is instantiated, every inst_req is a miss, and the fill write is removed. Latency and arbitration are otherwise identical.

Test Plan:
- Cold fetch 0x0000_1000, mc_done with 0x0000_0013 → inst_valid = 1, data 0x13. Refetch → same-cycle hit, no mc_new_task.
- dp_req = 2'b11 with inst miss pending, ARB_RR = 0 → port 0 granted first, then port 1, then inst. Each is issued only after the prior mc_done.
- ARB_RR = 1, dp_req = 2'b11 held for 4 tasks → grant order 0, 1, 0, 1.
- Load from port 1 (byte, signed) issued; clear_in pulses before mc_done → no dp_valid. Next request is granted the cycle after return to IDLE.
- Inst miss at 0x2000, clear during BUSY → no inst_valid. Later fetch of 0x2000 hits.
- Addresses 0x0000 and 0x0100 (same index, 64 lines): second fetch misses, evicts the first, then 0x0000 misses again.
